// File: rtl/flush_seq_ctrl.sv
// flush_seq_ctrl: fence-class flush sequencer with pulse targets, acknowledged targets and an optional timeout.
module flush_seq_ctrl #(
    parameter int unsigned NrPulse       = 12,
    parameter int unsigned NrAckCh       = 2,
    parameter int unsigned TimeoutCycles = 4096,
    parameter int unsigned MaskW         = NrPulse + NrAckCh
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               mispredict_i,
    input  logic               ex_i,
    input  logic               halt_csr_i,
    input  logic               req_valid_i,
    input  logic [MaskW-1:0]   req_mask_i,
    output logic               req_ready_o,
    input  logic [NrAckCh-1:0] ack_i,
    output logic               set_pc_commit_o,
    output logic               flush_if_o,
    output logic               flush_unissued_o,
    output logic               flush_id_o,
    output logic               flush_ex_o,
    output logic               flush_bp_o,
    output logic [NrPulse-1:0] flush_pulse_o,
    output logic [NrAckCh-1:0] flush_ack_req_o,
    output logic               halt_o,
    output logic               busy_o,
    output logic               timeout_o
);
    localparam int unsigned CntW = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nxt;
    logic [NrAckCh-1:0] req_nxt;
    logic [CntW-1:0] cnt;
    logic accept, expire;

    always_comb begin
        accept  = state == IDLE && req_valid_i;
        req_nxt = flush_ack_req_o;
        if (accept)
            req_nxt = req_mask_i[MaskW-1:NrPulse];
        else if (state == WAIT)
            req_nxt = flush_ack_req_o & ~ack_i;
        // a channel acknowledged on the deadline cycle still counts; only still-pending requests expire
        expire = TimeoutCycles > 0 && state == WAIT && |req_nxt && cnt == CntW'(TimeoutCycles - 1);
        if (expire)
            req_nxt = '0;
        state_nxt = |req_nxt ? WAIT : IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            flush_ack_req_o <= '0;
            cnt             <= '0;
            timeout_o       <= 1'b0;
        end else begin
            state           <= state_nxt;
            flush_ack_req_o <= req_nxt;
            cnt             <= state == WAIT ? cnt + 1'b1 : '0;
            timeout_o       <= expire;
        end
    end

    assign req_ready_o      = state == IDLE;
    assign busy_o           = state == WAIT;
    assign halt_o           = halt_csr_i || state == WAIT;
    assign set_pc_commit_o  = accept && !ex_i;
    assign flush_pulse_o    = accept ? req_mask_i[NrPulse-1:0] : '0;
    assign flush_if_o       = accept || mispredict_i || ex_i;
    assign flush_unissued_o = accept || mispredict_i || ex_i;
    assign flush_id_o       = accept || ex_i;
    assign flush_ex_o       = accept || ex_i;
    assign flush_bp_o       = ex_i;
endmodule
